// File: rtl/button_counter_ctrl.sv
// button_counter_ctrl: synchronises and debounces the two pmod buttons and turns them into
// press/release/long-press events that drive the manual / auto-run / pause LED counter.
module button_counter_ctrl #(
  parameter int unsigned COUNT_WIDTH       = 4,
  parameter int unsigned DEBOUNCE_CYCLES   = 120000,
  parameter int unsigned LONG_PRESS_CYCLES = 12000000,
  parameter int unsigned AUTO_TICK_CYCLES  = 6000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             pmod,
  output logic [COUNT_WIDTH-1:0] led,
  output logic                   mode,
  output logic                   count_wrap
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned LP_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int unsigned TK_W = (AUTO_TICK_CYCLES > 1) ? $clog2(AUTO_TICK_CYCLES) : 1;

  typedef enum logic [1:0] {
    MANUAL     = 2'd0,
    AUTO_RUN   = 2'd1,
    AUTO_PAUSE = 2'd2
  } state_t;

  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      level;
  logic [1:0]      db;
  logic [1:0]      db_d;
  logic [DB_W-1:0] db_cnt [2];

  logic [LP_W-1:0] hold;
  logic [TK_W-1:0] tick;
  state_t          state;
  state_t          state_nx;

  logic press1;
  logic release0;
  logic long_press;
  logic short_press;
  logic tick_done;
  logic inc;

  // Pins are active-low; everything past the synchroniser is active-high.
  assign level = ~sync2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      db    <= '0;
      db_d  <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= pmod;
      sync2 <= sync1;
      db_d  <= db;
      for (int unsigned i = 0; i < 2; i++) begin
        if (level[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt[i] <= '0;
          db[i]     <= level[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign press1   = db[1] & ~db_d[1];
  assign release0 = ~db[0] & db_d[0];

  // Hold counter saturates at the threshold, so reaching it marks the hold as long.
  always_ff @(posedge clk) begin
    if (!rst_n || !db[0]) begin
      hold <= '0;
    end else if (hold != LP_W'(LONG_PRESS_CYCLES)) begin
      hold <= hold + LP_W'(1);
    end
  end

  assign long_press  = db[0] && (hold == LP_W'(LONG_PRESS_CYCLES - 1));
  assign short_press = release0 && (hold != LP_W'(LONG_PRESS_CYCLES));
  assign tick_done   = (state == AUTO_RUN) && (tick == TK_W'(AUTO_TICK_CYCLES - 1));
  assign inc         = ((state == MANUAL) && press1) || tick_done;

  always_comb begin
    state_nx = state;
    case (state)
      MANUAL: begin
        if (long_press) state_nx = AUTO_RUN;
      end
      AUTO_RUN: begin
        if (long_press)  state_nx = MANUAL;
        else if (press1) state_nx = AUTO_PAUSE;
      end
      AUTO_PAUSE: begin
        if (long_press)  state_nx = MANUAL;
        else if (press1) state_nx = AUTO_RUN;
      end
      default: state_nx = MANUAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= MANUAL;
      tick       <= '0;
      mode       <= 1'b0;
      led        <= '0;
      count_wrap <= 1'b0;
    end else begin
      state <= state_nx;
      mode  <= (state_nx != MANUAL);
      // Tick only advances while staying in AUTO_RUN, so a resume always starts a full period.
      if ((state == AUTO_RUN) && (state_nx == AUTO_RUN) && !tick_done) begin
        tick <= tick + TK_W'(1);
      end else begin
        tick <= '0;
      end
      if (short_press) begin
        led        <= '0;
        count_wrap <= 1'b0;
      end else if (inc) begin
        led        <= led + COUNT_WIDTH'(1);
        count_wrap <= &led;
      end else begin
        count_wrap <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_counter_ctrl.sv
// tb_button_counter_ctrl: directed, table-driven and random checks of button_counter_ctrl
// against an event-level reference model of the debounce / hold / auto-tick rules.
module tb_button_counter_ctrl;

  localparam int W    = 4;
  localparam int D    = 4;
  localparam int L    = 20;
  localparam int T    = 8;
  localparam int MAXC = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic [1:0]   pmod;
  logic [W-1:0] led;
  logic         mode;
  logic         count_wrap;

  int checks = 0;
  int errors = 0;
  int t;
  int wraps = 0;
  int wraps_led0 = 0;
  bit mon_en = 0;

  button_counter_ctrl #(
    .COUNT_WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .LONG_PRESS_CYCLES(L),
    .AUTO_TICK_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pmod(pmod),
    .led(led),
    .mode(mode),
    .count_wrap(count_wrap)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pin history window, debounced levels, events, and the count/mode rules.
  bit hist [2][D+2];
  bit mdb [2];
  bit mdb_prev [2];
  int held;
  bit long_fired;
  int cyc = 0;
  int run_start;
  int m_state;
  int m_led;
  bit m_mode;
  bit m_wrap;

  task automatic model_step(input bit rst, input bit [1:0] pin);
    bit press1, release0, lp, shortp, expiry, inc, same, v;
    int nxt;
    cyc++;
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int j = 0; j < D + 2; j++) hist[b][j] = 1'b1;
        mdb[b] = 0;
        mdb_prev[b] = 0;
      end
      held = 0; long_fired = 0; m_state = 0; m_led = 0; m_mode = 0; m_wrap = 0;
      return;
    end
    press1   = mdb[1] && !mdb_prev[1];
    release0 = !mdb[0] && mdb_prev[0];
    lp       = mdb[0] && (held == L - 1);
    shortp   = release0 && !long_fired;
    expiry   = (m_state == 1) && (((cyc - run_start) % T) == 0);
    inc      = ((m_state == 0) && press1) || expiry;
    if (shortp) begin
      m_led = 0; m_wrap = 0;
    end else if (inc) begin
      m_wrap = (m_led == MAXC);
      m_led  = (m_led + 1) % (MAXC + 1);
    end else begin
      m_wrap = 0;
    end
    nxt = m_state;
    if (lp) nxt = (m_state == 0) ? 1 : 0;
    else if (press1 && m_state != 0) nxt = (m_state == 1) ? 2 : 1;
    if (nxt == 1 && m_state != 1) run_start = cyc;
    m_state = nxt;
    m_mode  = (nxt != 0);
    if (mdb[0]) begin
      if (lp) long_fired = 1;
      held++;
    end else begin
      held = 0; long_fired = 0;
    end
    for (int b = 0; b < 2; b++) begin
      mdb_prev[b] = mdb[b];
      for (int j = D + 1; j > 0; j--) hist[b][j] = hist[b][j-1];
      hist[b][0] = pin[b];
      v = hist[b][2];
      same = 1;
      for (int j = 3; j <= D + 1; j++) if (hist[b][j] != v) same = 0;
      if (same && ((!v) != mdb[b])) mdb[b] = !v;
    end
  endtask

  always @(posedge clk) begin
    model_step(rst_n, pmod);
    #1;
    if (mon_en) begin
      chk("mon_led", int'(led), m_led);
      chk("mon_mode", int'(mode), int'(m_mode));
      chk("mon_wrap", int'(count_wrap), int'(m_wrap));
    end
  end

  always @(negedge clk) begin
    if (count_wrap === 1'b1) begin
      wraps++;
      if (led == 0) wraps_led0++;
    end
  end

  task automatic go(input int n);
    while (t < n) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic press(input int b, input int hold_cyc);
    pmod[b] = 1'b0;
    repeat (hold_cyc) @(negedge clk);
    pmod[b] = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  typedef struct {
    int hold;
    int exp_led;
    int exp_wraps;
  } vec_t;
  vec_t tbl [16];

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int wr0;
    for (int i = 0; i < 16; i++) begin
      tbl[i].hold      = 5 + (i % 3);
      tbl[i].exp_led   = (i + 1) % 16;
      tbl[i].exp_wraps = (i == 15) ? 1 : 0;
    end

    rst_n = 0;
    pmod  = 2'b11;
    repeat (3) @(negedge clk);
    rst_n  = 1;
    mon_en = 1;
    chk("reset_led", int'(led), 0);
    chk("reset_mode", int'(mode), 0);
    chk("reset_wrap", int'(count_wrap), 0);

    // Bouncing STEP button: only the final stable level counts.
    for (int i = 0; i < 10; i++) begin
      pmod[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) @(negedge clk);
    end
    t = 0;
    pmod[1] = 1'b0;
    go(6);  chk("bounce_before", int'(led), 0);
    go(7);  chk("bounce_after", int'(led), 1);
    go(30); pmod[1] = 1'b1;
    go(45); chk("bounce_single", int'(led), 1);

    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    wraps = 0;
    wraps_led0 = 0;
    for (int i = 0; i < 16; i++) begin
      press(1, tbl[i].hold);
      chk("tbl_led", int'(led), tbl[i].exp_led);
      chk("tbl_wraps", wraps, tbl[i].exp_wraps);
      chk("tbl_wrap_led0", wraps_led0, tbl[i].exp_wraps);
    end

    // Short CLEAR press from led=5.
    for (int i = 0; i < 5; i++) press(1, 6);
    chk("pre_clear_led", int'(led), 5);
    pmod[0] = 1'b0;
    repeat (10) @(negedge clk);
    t = 0;
    pmod[0] = 1'b1;
    go(6); chk("clear_before", int'(led), 5);
    go(7); chk("clear_after", int'(led), 0);
    chk("clear_mode", int'(mode), 0);
    repeat (20) @(negedge clk);

    // Long press into auto-run, pause, resume, then reset mid-run.
    t = 0;
    pmod[0] = 1'b0;
    go(40);  pmod[0] = 1'b1;
    go(60);  chk("auto_led60", int'(led), 4);
    chk("auto_mode", int'(mode), 1);
    pmod[1] = 1'b0;
    go(66);  chk("auto_led66", int'(led), 5);
    pmod[1] = 1'b1;
    go(100); chk("pause_led", int'(led), 5);
    chk("pause_mode", int'(mode), 1);
    pmod[1] = 1'b0;
    go(106); pmod[1] = 1'b1;
    go(114); chk("resume_before", int'(led), 5);
    go(115); chk("resume_after", int'(led), 6);
    go(139); chk("run_led9", int'(led), 9);
    go(140); rst_n = 1'b0;
    go(141);
    chk("rst_led", int'(led), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_wrap", int'(count_wrap), 0);
    rst_n = 1'b1;
    go(171);
    chk("rst_idle_led", int'(led), 0);
    chk("rst_idle_mode", int'(mode), 0);

    // Short-press release0 and press1 landing on the same edge: clear wins.
    press(1, 6);
    press(1, 6);
    chk("same_pre_led", int'(led), 2);
    wr0 = wraps;
    pmod[0] = 1'b0;
    repeat (8) @(negedge clk);
    t = 0;
    pmod[0] = 1'b1;
    pmod[1] = 1'b0;
    go(6); chk("same_before", int'(led), 2);
    go(7); chk("same_led", int'(led), 0);
    chk("same_wrap", int'(count_wrap), 0);
    chk("same_no_wrap", wraps, wr0);
    pmod[1] = 1'b1;
    repeat (15) @(negedge clk);

    // Random button activity, checked every cycle by the model.
    for (int s = 0; s < 220; s++) begin
      pmod[0] = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      pmod[1] = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      repeat ($urandom_range(1, 35)) @(negedge clk);
    end
    pmod = 2'b11;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
